vec_bitwise_pipe: RTL and testbench
===================================

VEC_BITWISE_PIPE -- requirements
Module: vec_bitwise_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the lane width in bits; legal values are powers of two, 2..64.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the completed-transaction counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand set presented.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port op  input  3  operation select, sampled with operands.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B; its low log2(WIDTH) bits are also the rotate amount.
REQ-010 SHALL have port c  input  WIDTH  operand C; per-bit select for MUX.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port out  output  WIDTH  result.
REQ-014 SHALL have port done_cnt  output  CNT_W  saturating count of results consumed.

Function
REQ-015 SHALL decode op as follows: 0 PASS out=a; 1 REVERSE out[i]=a[WIDTH-1-i]; 2 AND a&b; 3 OR a|b; 4 XOR a^b; 5 MUX (a&c)|(b&~c); 6 ROTL, a rotated left by b[log2(WIDTH)-1:0]; 7 IMPLY (a&b)|~a.
REQ-016 SHALL accept a transfer on the input side when in_valid&&in_ready, and on the output side when out_valid&&out_ready.
REQ-017 SHALL be a two-stage pipeline: S1 registers op/a/b/c, and S2 registers the computed result; all results are bitwise and WIDTH wide, with no carries and no truncation.
REQ-018 SHALL present the result on out with out_valid=1 two cycles after acceptance when there is no backpressure (latency 2).
REQ-019 SHALL sustain a throughput of one transfer per cycle while out_ready=1.
REQ-020 SHALL advance S1 to S2 when S1 is valid and (S2 is empty or the output transfer occurs this cycle).
REQ-021 SHALL drive in_ready = !S1_valid || S1 advances this cycle, combinationally from the current state and out_ready, with no dependence on in_valid.
REQ-022 SHALL hold out and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL hold at most 2 transactions in flight; with out_ready=0, in_ready SHALL fall after 2 accepts.
REQ-024 SHALL deliver results in acceptance order, with none dropped or duplicated.
REQ-025 SHALL ignore a, b, c and op when in_valid=0, or when in_valid=1 and in_ready=0.
REQ-026 SHALL allow an output transfer and an input transfer in the same cycle with the pipeline full, with no bubble.
REQ-027 SHALL increment done_cnt by 1 on each output transfer, saturate at 2^CNT_W-1, and never wrap.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, clear S1_valid, S2_valid, out to 0 and done_cnt to 0.
REQ-029 SHALL hold in_ready=0 while rst=1, and SHALL allow in_ready=1 the first cycle after rst deasserts.
REQ-030 SHALL discard in-flight transactions when rst is asserted mid-operation; no result from before reset SHALL appear afterwards.

Verification
REQ-031 SHALL be verified with WIDTH=8, out_ready=1, by the following per-op checks; each result SHALL appear 2 cycles after acceptance with done_cnt+1:
- op=1, a=0x01 -> out=0x80.
- op=5, a=0xF0, b=0x0F, c=0xAA -> out=0xA5.
- op=7, a=0xF0, b=0x30 -> out=0x3F.
- op=6, a=0x81, b=0x03 -> out=0x0C.
REQ-032 SHALL be verified by a backpressure test: out_ready=0; send XOR a=0xFF with b = 0x0F, 0x33, 0x55 on consecutive cycles -> accepts 2, in_ready=0 on the third; out held at 0xF0; raise out_ready -> 0xF0, 0xCC, 0xAA in order, done_cnt=3.
REQ-033 SHALL be verified by a streaming test: 16 back-to-back transfers with out_ready=1 -> in_ready remains 1, and 16 results appear on consecutive cycles starting at cycle 2.
REQ-034 SHALL be verified by a mid-operation reset test: 2 transactions in flight, rst=1 for one cycle -> out_valid=0, done_cnt=0, out=0x00, and no stale result thereafter.
REQ-035 SHALL be verified by a saturation test with CNT_W=4: 20 consumed results -> done_cnt=15 and it remains at 15.

Source files
------------

// File: rtl/vec_bitwise_pipe.sv
// Two-stage bitwise vector unit: S1 captures the operand set, S2 holds the result.
// Valid/ready on both sides; S1 and S2 form a 2-entry skid so full-rate streaming never bubbles.
module vec_bitwise_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [CNT_W-1:0] done_cnt
);

   localparam int SH_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int STAGES = 2;

   typedef enum logic [2:0] {
      OP_PASS  = 3'd0,
      OP_REV   = 3'd1,
      OP_AND   = 3'd2,
      OP_OR    = 3'd3,
      OP_XOR   = 3'd4,
      OP_MUX   = 3'd5,
      OP_ROTL  = 3'd6,
      OP_IMPLY = 3'd7
   } op_e;

   typedef struct packed {
      op_e              op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] c;
   } req_t;

   req_t               s1;
   logic [STAGES:1]    vld_pipe;
   logic               fire_in;
   logic               fire_out;
   logic               adv1;
   logic [WIDTH-1:0]   res;
   logic [WIDTH-1:0]   rev;
   logic [2*WIDTH-1:0] rot_w;

   // S1 may move on whenever S2 is free or S2 is being drained this same cycle.
   assign fire_out  = vld_pipe[2] & out_ready;
   assign adv1      = vld_pipe[1] & (~vld_pipe[2] | out_ready);
   assign in_ready  = ~rst & (~vld_pipe[1] | adv1);
   assign fire_in   = in_valid & in_ready;
   assign out_valid = vld_pipe[2];

   // Doubling the word turns the rotate into a plain shift; the upper half is the result.
   assign rot_w = {s1.a, s1.a} << s1.b[SH_W-1:0];

   always_comb begin
      rev = '0;
      for (int i = 0; i < WIDTH; i++)
         rev[i] = s1.a[WIDTH-1-i];
   end

   always_comb begin
      res = s1.a;
      case (s1.op)
         OP_PASS:  res = s1.a;
         OP_REV:   res = rev;
         OP_AND:   res = s1.a & s1.b;
         OP_OR:    res = s1.a | s1.b;
         OP_XOR:   res = s1.a ^ s1.b;
         OP_MUX:   res = (s1.a & s1.c) | (s1.b & ~s1.c);
         OP_ROTL:  res = rot_w[2*WIDTH-1:WIDTH];
         OP_IMPLY: res = (s1.a & s1.b) | ~s1.a;
         default:  res = s1.a;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         out      <= '0;
         done_cnt <= '0;
      end else begin
         vld_pipe[1] <= fire_in | (vld_pipe[1] & ~adv1);
         vld_pipe[2] <= adv1 | (vld_pipe[2] & ~out_ready);
         if (adv1)
            out <= res;
         if (fire_out && (done_cnt != '1))
            done_cnt <= done_cnt + CNT_W'(1);
      end
   end

   // Operand capture needs no reset: it is qualified by vld_pipe[1].
   always_ff @(posedge clk) begin
      if (fire_in)
         s1 <= '{op: op_e'(op), a: a, b: b, c: c};
   end

endmodule

// File: tb/tb_vec_bitwise_pipe.sv
// Bench for vec_bitwise_pipe: queue-based reference model checked every cycle,
// plus directed literal vectors for ops, backpressure, streaming, reset and counter saturation.
module tb_vec_bitwise_pipe;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       out_ready;
   logic [2:0] op;
   logic [7:0] a, b, c;

   logic        in_ready, out_valid;
   logic [7:0]  out;
   logic [15:0] done_cnt;
   logic        s_in_ready, s_out_valid;
   logic [7:0]  s_out;
   logic [3:0]  s_done_cnt;

   int checks = 0;
   int errors = 0;

   vec_bitwise_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .done_cnt(done_cnt)
   );

   vec_bitwise_pipe #(.WIDTH(8), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .op(op),
      .a(a), .b(b), .c(c), .out_valid(s_out_valid), .out_ready(out_ready),
      .out(s_out), .done_cnt(s_done_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Reference written bit-by-bit from the op table.
   function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x,
                                         input logic [7:0] y, input logic [7:0] z);
      logic [7:0] r;
      int sh;
      r  = '0;
      sh = int'(y[2:0]);
      for (int i = 0; i < 8; i++) begin
         case (o)
            3'd0: r[i] = x[i];
            3'd1: r[i] = x[7-i];
            3'd2: r[i] = x[i] && y[i];
            3'd3: r[i] = x[i] || y[i];
            3'd4: r[i] = x[i] != y[i];
            3'd5: r[i] = z[i] ? x[i] : y[i];
            3'd6: r[(i+sh)%8] = x[i];
            default: r[i] = x[i] ? y[i] : 1'b1;
         endcase
      end
      return r;
   endfunction

   // Model: ordered queue of pending results; h2 says the oldest one is on the output.
   logic [7:0]  mq[$];
   bit          h2 = 0;
   bit          mok = 0;
   int unsigned mcnt = 0;

   always @(negedge clk) begin
      logic exp_rdy;
      bit   fo, fi;
      exp_rdy = !rst && !(mq.size() == 2 && !out_ready);
      if (mok) begin
         chk("cmp_in_ready", in_ready, exp_rdy);
         chk("cmp_out_valid", out_valid, h2);
         if (h2 && out_valid)
            chk("cmp_out", out, mq[0]);
         chk("cmp_done_cnt", done_cnt, (mcnt > 65535) ? 65535 : mcnt);
         chk("cmp_sat_out_valid", s_out_valid, h2);
         chk("cmp_sat_done_cnt", s_done_cnt, (mcnt > 15) ? 15 : mcnt);
      end
      if (rst) begin
         mq.delete();
         h2   = 0;
         mcnt = 0;
         mok  = 1;
      end else if (mok) begin
         fo = h2 && out_ready;
         fi = in_valid && exp_rdy;
         if (fo) begin
            void'(mq.pop_front());
            h2 = 0;
            mcnt++;
         end
         if (mq.size() > 0 && !h2)
            h2 = 1;
         if (fi)
            mq.push_back(ref_op(op, a, b, c));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   int exp_done;

   task automatic send_lit(input string nm, input logic [2:0] o, input logic [7:0] x,
                           input logic [7:0] y, input logic [7:0] z, input logic [7:0] exp);
      chk({nm, "_model"}, ref_op(o, x, y, z), exp);
      in_valid = 1'b1; op = o; a = x; b = y; c = z;
      #1;
      chk({nm, "_in_ready"}, in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();
      chk({nm, "_out_valid"}, out_valid, 1'b1);
      chk({nm, "_out"}, out, exp);
      chk({nm, "_done_before"}, done_cnt, exp_done);
      tick();
      exp_done++;
      chk({nm, "_done_after"}, done_cnt, exp_done);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; a = '0; b = '0; c = '0;
      tick(); tick(); tick();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out", out, 8'h00);
      chk("rst_done_cnt", done_cnt, 16'd0);
      chk("rst_in_ready", in_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1'b1);

      exp_done = 0;
      send_lit("rev",   3'd1, 8'h01, 8'h00, 8'h00, 8'h80);
      send_lit("mux",   3'd5, 8'hF0, 8'h0F, 8'hAA, 8'hA5);
      send_lit("imply", 3'd7, 8'hF0, 8'h30, 8'h00, 8'h3F);
      send_lit("rotl",  3'd6, 8'h81, 8'h03, 8'h00, 8'h0C);
      send_lit("pass",  3'd0, 8'h5C, 8'hFF, 8'hFF, 8'h5C);
      send_lit("and",   3'd2, 8'hCC, 8'hAA, 8'h00, 8'h88);
      send_lit("or",    3'd3, 8'hC0, 8'h0A, 8'h00, 8'hCA);
      send_lit("xor",   3'd4, 8'hFF, 8'h3C, 8'h00, 8'hC3);
      send_lit("rotl0", 3'd6, 8'h96, 8'h08, 8'h00, 8'h96);

      // Backpressure: two accepts fill the pipe, third waits.
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; op = 3'd4; a = 8'hFF; b = 8'h0F; c = 8'h00;
      tick();
      b = 8'h33;
      tick();
      b = 8'h55;
      #1;
      chk("bp_in_ready_low", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_first", out, 8'hF0);
      tick(); tick();
      chk("bp_out_held", out, 8'hF0);
      chk("bp_in_ready_held", in_ready, 1'b0);
      out_ready = 1'b1;
      #1;
      chk("bp_release_out", out, 8'hF0);
      chk("bp_release_in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("bp_out_second", out, 8'hCC);
      tick();
      chk("bp_out_third", out, 8'hAA);
      tick();
      chk("bp_drained", out_valid, 1'b0);
      chk("bp_done_cnt", done_cnt, 16'd3);

      // Streaming: 16 back-to-back XORs with a fixed mask.
      for (int t = 0; t < 18; t++) begin
         if (t < 16) begin
            in_valid = 1'b1; op = 3'd4; a = 8'(t); b = 8'h5A;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (t < 16)
            chk("stream_in_ready", in_ready, 1'b1);
         if (t >= 2) begin
            chk("stream_out_valid", out_valid, 1'b1);
            chk("stream_out", out, 8'(t - 2) ^ 8'h5A);
         end
         tick();
      end

      // Mid-operation reset with two transactions in flight.
      out_ready = 1'b0;
      in_valid = 1'b1; op = 3'd0; a = 8'h11;
      tick();
      a = 8'h22;
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      chk("mrst_out_valid", out_valid, 1'b0);
      chk("mrst_done_cnt", done_cnt, 16'd0);
      chk("mrst_out", out, 8'h00);
      chk("mrst_in_ready", in_ready, 1'b0);
      rst = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         tick();
         chk("mrst_no_stale", out_valid, 1'b0);
      end

      // Saturation of the 4-bit counter.
      for (int t = 0; t < 20; t++) begin
         in_valid = 1'b1; op = 3'd3; a = 8'(t); b = 8'h80;
         tick();
      end
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk("sat_done_15", s_done_cnt, 4'd15);
      chk("sat_wide_done_20", done_cnt, 16'd20);
      in_valid = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk("sat_done_stays", s_done_cnt, 4'd15);

      // Mixed traffic with random stalls, checked by the model every cycle.
      for (int t = 0; t < 200; t++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         op = 3'($urandom); a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
